dump_scheduler: RTL and testbench

DUMP_SCHEDULER -- requirements
Module: dump_scheduler

---
 rtl/dump_scheduler.sv | 164 ++++++++++++++++
 tb/tb_dump_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dump_scheduler.sv
// dump_scheduler: streams every register-file word, then every data-memory word, to a UART TX, LSB byte first.
// Optional feature macro DUMP_CHECKSUM_EN appends one XOR checksum byte to each frame.
module dump_scheduler #(
  parameter int len            = 32,
  parameter int LEN_DATA       = 8,
  parameter int cant_regs      = 32,
  parameter int cant_mem_datos = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [len-1:0]                    reg_data,
  input  logic [len-1:0]                    mem_data,
  output logic [$clog2(cant_regs)-1:0]      reg_addr,
  output logic [$clog2(cant_mem_datos)-1:0] mem_addr,
  output logic                              tx_start,
  input  logic                              tx_done,
  output logic [LEN_DATA-1:0]               uart_data_out,
  output logic                              busy,
  output logic                              done
);

  localparam int RA_W  = $clog2(cant_regs);
  localparam int MA_W  = $clog2(cant_mem_datos);
  localparam int WORDS = cant_regs + cant_mem_datos;
  localparam int WI_W  = $clog2(WORDS);
  localparam int BYTES = len / LEN_DATA;
  localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [WI_W-1:0] LAST_WORD = WI_W'(WORDS - 1);
  localparam logic [WI_W-1:0] FIRST_MEM = WI_W'(cant_regs);
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES - 1);

  // state     | meaning
  // IDLE      | waiting for start
  // LOAD      | latch addressed word into word_reg, raise tx_start for byte 0
  // SEND      | tx_start high for the current byte
  // WAIT_TX   | byte in flight, waiting for tx_done
  // NEXT_WORD | advance word index or end the frame
  // CHECKSUM  | send XOR checksum byte and wait for tx_done (DUMP_CHECKSUM_EN only)
  // FINISH    | done pulse, back to IDLE
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_TX,
    NEXT_WORD,
`ifdef DUMP_CHECKSUM_EN
    CHECKSUM,
`endif
    FINISH
  } state_t;

  state_t                           state;
  logic [WI_W-1:0]                  word_idx;
  logic [BI_W-1:0]                  byte_idx;
  logic [BYTES-1:0][LEN_DATA-1:0]   word_reg;
  logic [WI_W-1:0]                  next_word;
  logic [BI_W-1:0]                  next_byte;
  logic [len-1:0]                   sel_data;
`ifdef DUMP_CHECKSUM_EN
  logic [LEN_DATA-1:0]              csum;
`endif

  assign next_word = word_idx + WI_W'(1);
  assign next_byte = byte_idx + BI_W'(1);
  assign sel_data  = (word_idx < FIRST_MEM) ? reg_data : mem_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      word_idx      <= '0;
      byte_idx      <= '0;
      word_reg      <= '0;
      reg_addr      <= '0;
      mem_addr      <= '0;
      tx_start      <= 1'b0;
      uart_data_out <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            word_idx <= '0;
            byte_idx <= '0;
            reg_addr <= '0;
            busy     <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        // Byte 0 goes straight from the read port so tx_start lands one cycle after LOAD.
        LOAD: begin
          word_reg      <= sel_data;
          uart_data_out <= sel_data[LEN_DATA-1:0];
          tx_start      <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          csum          <= csum ^ sel_data[LEN_DATA-1:0];
`endif
          state         <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (tx_done) begin
            if (byte_idx != LAST_BYTE) begin
              byte_idx      <= next_byte;
              uart_data_out <= word_reg[next_byte];
              tx_start      <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
              csum          <= csum ^ word_reg[next_byte];
`endif
              state         <= SEND;
            end else begin
              state <= NEXT_WORD;
            end
          end
        end
        NEXT_WORD: begin
          if (word_idx == LAST_WORD) begin
`ifdef DUMP_CHECKSUM_EN
            uart_data_out <= csum;
            tx_start      <= 1'b1;
            state         <= CHECKSUM;
`else
            done  <= 1'b1;
            state <= FINISH;
`endif
          end else begin
            word_idx <= next_word;
            byte_idx <= '0;
            if (next_word < FIRST_MEM) reg_addr <= RA_W'(next_word);
            else                       mem_addr <= MA_W'(next_word - FIRST_MEM);
            state    <= LOAD;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        // tx_done is ignored in the cycle tx_start is still high.
        CHECKSUM: begin
          if (!tx_start && tx_done) begin
            done  <= 1'b1;
            state <= FINISH;
          end
        end
`endif
        FINISH: begin
          busy     <= 1'b0;
          word_idx <= '0;
          byte_idx <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dump_scheduler.sv
// Directed bench for dump_scheduler: UART responder returns tx_done 3 cycles after each tx_start.
// Frame contents are predicted from the bench's own register/memory images.
module tb_dump_scheduler;

  localparam int NREG = 32;
  localparam int NMEM = 16;
`ifdef DUMP_CHECKSUM_EN
  localparam int FRAME = 4 * (NREG + NMEM) + 1;
`else
  localparam int FRAME = 4 * (NREG + NMEM);
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        tx_done = 1'b0;
  logic        tx_start, busy, done;
  logic [31:0] reg_data, mem_data;
  logic [4:0]  reg_addr;
  logic [3:0]  mem_addr;
  logic [7:0]  uart_data_out;

  logic [31:0] regs [NREG];
  logic [31:0] mems [NMEM];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] cap[$];
  int tx_cyc[$];
  int done_cnt = 0, adj_viol = 0, hold_viol = 0, busy_viol = 0, resp_cnt = 0;
  logic spur_en = 1'b0;
  logic prev_tx = 1'b0, prev_done = 1'b0;
  logic [7:0] last_sent = '0;

  dump_scheduler dut (
    .clk(clk), .reset(reset), .start(start),
    .reg_data(reg_data), .mem_data(mem_data),
    .reg_addr(reg_addr), .mem_addr(mem_addr),
    .tx_start(tx_start), .tx_done(tx_done),
    .uart_data_out(uart_data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign reg_data = regs[reg_addr];
  assign mem_data = mems[mem_addr];

  // UART TX stand-in plus frame monitor
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (reset) resp_cnt = 0;
    else if (resp_cnt > 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) tx_done = 1'b1;
      else if (uart_data_out != last_sent) hold_viol++;
    end
    if (tx_start) begin
      cap.push_back(uart_data_out);
      tx_cyc.push_back(cyc);
      last_sent = uart_data_out;
      resp_cnt = 3;
      if (spur_en) tx_done = 1'b1;
    end
    if (done) begin
      done_cnt++;
      if (!busy) busy_viol++;
    end
    if ((tx_start && prev_done) || (done && prev_tx)) adj_viol++;
    prev_tx = tx_start;
    prev_done = done;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input int i);
    if (i < cap.size()) return cap[i];
    return 8'hxx;
  endfunction

  function automatic int get_cyc(input int i);
    if (i < tx_cyc.size()) return tx_cyc[i];
    return -1;
  endfunction

  task automatic fill_index();
    for (int i = 0; i < NREG; i++) regs[i] = i;
    for (int i = 0; i < NMEM; i++) mems[i] = i;
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int i = 0; i < NREG; i++) regs[i] = v;
    for (int i = 0; i < NMEM; i++) mems[i] = v;
  endtask

  task automatic pulse_start(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == d0) check({tag, "_timeout"}, 1, 0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic compare_frame(input int base, input string tag);
    int bad = 0;
    logic [7:0] cs = '0;
    logic [7:0] e;
    logic [31:0] word;
    check({tag, "_len"}, 64'(cap.size() - base), FRAME);
    for (int w = 0; w < NREG + NMEM; w++) begin
      word = (w < NREG) ? regs[w] : mems[w - NREG];
      for (int b = 0; b < 4; b++) begin
        e = 8'(word >> (8 * b));
        cs = cs ^ e;
        if (get_byte(base + 4 * w + b) !== e) bad++;
      end
    end
`ifdef DUMP_CHECKSUM_EN
    if (get_byte(base + FRAME - 1) !== cs) bad++;
`endif
    check({tag, "_bytes"}, bad, 0);
  endtask

  int base, d0, t0, n;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill_index();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_uart_data", uart_data_out, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // r0 = 0x11223344: byte order and start latency
    regs[0] = 32'h11223344;
    base = cap.size(); d0 = done_cnt;
    pulse_start(t0);
    check("a_busy_load", busy, 1);
    wait_done(d0, "a");
    check("a_latency", 64'(get_cyc(base) - t0), 2);
    check("a_byte0", get_byte(base), 8'h44);
    check("a_byte1", get_byte(base + 1), 8'h33);
    check("a_byte2", get_byte(base + 2), 8'h22);
    check("a_byte3", get_byte(base + 3), 8'h11);
    compare_frame(base, "a_frame");
    check("a_done_cnt", 64'(done_cnt - d0), 1);
    check("a_busy_after", busy, 0);

    // every word holds its own index
    fill_index();
    base = cap.size(); d0 = done_cnt;
    pulse_start(t0);
    wait_done(d0, "b");
    compare_frame(base, "b_frame");
    check("b_byte128_mem0", get_byte(base + 128), 8'h00);
    check("b_byte4_reg1", get_byte(base + 4), 8'h01);
    check("b_done_cnt", 64'(done_cnt - d0), 1);
    check("b_busy_after", busy, 0);

    // restarts and spurious tx_done mid-frame
    for (int i = 0; i < NREG; i++) regs[i] = 32'hA0B0C0D0 ^ i;
    for (int i = 0; i < NMEM; i++) mems[i] = 32'h50607080 + i;
    spur_en = 1'b1;
    base = cap.size(); d0 = done_cnt;
    pulse_start(t0);
    n = 0;
    while (cap.size() - base < 20 && n < 2000) begin @(posedge clk); #1; n++; end
    pulse_start(t0);
    n = 0;
    while (cap.size() - base < 100 && n < 2000) begin @(posedge clk); #1; n++; end
    pulse_start(t0);
    wait_done(d0, "c");
    spur_en = 1'b0;
    compare_frame(base, "c_frame");
    check("c_done_cnt", 64'(done_cnt - d0), 1);

    // reset after byte 50, then a clean frame
    base = cap.size(); d0 = done_cnt;
    pulse_start(t0);
    n = 0;
    while (cap.size() - base < 50 && n < 2000) begin @(posedge clk); #1; n++; end
    check("d_reached_50", 64'(cap.size() - base >= 50), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("d_rst_outputs", {tx_start, done, busy, uart_data_out, reg_addr, mem_addr}, 0);
    reset = 1'b0;
    n = cap.size();
    repeat (30) @(posedge clk);
    #1;
    check("d_no_resume", 64'(cap.size() - n), 0);
    check("d_no_done", 64'(done_cnt - d0), 0);
    check("d_idle_busy", busy, 0);
    base = cap.size(); d0 = done_cnt;
    pulse_start(t0);
    wait_done(d0, "d2");
    check("d_first_r0", get_byte(base), 8'hD0);
    compare_frame(base, "d_frame");
    check("d_done_cnt", 64'(done_cnt - d0), 1);

`ifdef DUMP_CHECKSUM_EN
    fill_const(32'hA5A5A5A5);
    base = cap.size(); d0 = done_cnt;
    pulse_start(t0);
    wait_done(d0, "e");
    compare_frame(base, "e_frame");
    check("e_csum", get_byte(base + FRAME - 1), 8'h00);

    fill_const(32'h0);
    regs[1] = 32'h000000FF;
    base = cap.size(); d0 = done_cnt;
    pulse_start(t0);
    wait_done(d0, "f");
    compare_frame(base, "f_frame");
    check("f_csum", get_byte(base + FRAME - 1), 8'hFF);
`endif

    check("no_adjacent_pulses", adj_viol, 0);
    check("uart_data_hold", hold_viol, 0);
    check("busy_during_done", busy_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
